// File: rtl/seq_alu_acc_if.sv
// Operation request / result bus between input conditioning and seq_alu_acc.
// The master drives the request fields; the slave (the ALU) returns result, busy and done.
interface seq_alu_acc_if #(
    parameter int W = 4
);
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           use_acc;
    logic [2*W-1:0] result;
    logic           busy;
    logic           done;

    modport master (
        output start, op, a, b, use_acc,
        input  result, busy, done
    );

    modport slave (
        input  start, op, a, b, use_acc,
        output result, busy, done
    );
endinterface

// File: rtl/seq_alu_acc.sv
// Registered ALU with a 2*W-bit accumulator that can feed back as operand B.
// Single-cycle ops complete on the accept edge; MUL is shift-add, one bit per edge.
module seq_alu_acc #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    seq_alu_acc_if.slave bus
);
    localparam int RW = 2 * W;
    localparam int CW = $clog2(W + 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   result_q, result_d;
    logic [RW-1:0]   mcand_q, mcand_d;
    logic [RW-1:0]   prod_q, prod_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;

    logic [W-1:0]    op_b;
    logic [W:0]      sum;
    logic [RW-1:0]   shl_res;
    logic [RW-1:0]   alu_res;
    logic [RW-1:0]   prod_acc;

    // Operand B comes from the accumulator as it stands at the accept edge.
    always_comb begin
        op_b = bus.use_acc ? result_q[W-1:0] : bus.b;
        sum  = {1'b0, bus.a} + {1'b0, op_b};

        if (32'(bus.a) >= 32'(RW)) begin
            shl_res = '0;
        end else begin
            shl_res = {{W{1'b0}}, op_b} << bus.a;
        end

        unique case (bus.op)
            3'b001:  alu_res = RW'(sum);
            3'b010:  alu_res = {bus.a | op_b, bus.a ^ op_b};
            3'b011:  alu_res = RW'(|{bus.a, op_b});
            3'b100:  alu_res = RW'(&{bus.a, op_b});
            3'b101:  alu_res = {bus.a, op_b};
            3'b111:  alu_res = shl_res;
            default: alu_res = result_q;
        endcase
    end

    assign prod_acc = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == 3'b110) begin
                        state_d  = MUL;
                        mcand_d  = RW'(bus.a);
                        mplier_d = op_b;
                        prod_d   = '0;
                        cnt_d    = CW'(W);
                    end else begin
                        result_d = alu_res;
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                prod_d   = prod_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                // Last multiplier bit: publish the completed product directly.
                if (cnt_q == CW'(1)) begin
                    result_d = prod_acc;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            result_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = (state_q == MUL);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_seq_alu_acc.sv
// Randomised and directed checks of seq_alu_acc against a behavioural model.
module tb_seq_alu_acc;
    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic clk = 1'b0;
    logic resetn;

    seq_alu_acc_if #(.W(W)) bus ();

    seq_alu_acc #(.W(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: accumulator value, edges left in a multiply, pending product.
    int unsigned exp_result = 0;
    int unsigned exp_done   = 0;
    int          mul_left   = 0;
    int unsigned mul_prod   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned model_op(input int unsigned op, input int unsigned a,
                                             input int unsigned b);
        int unsigned full = (1 << W) - 1;
        int unsigned r;
        case (op)
            1:       r = a + b;
            2:       r = ((a | b) << W) | (a ^ b);
            3:       r = (a != 0 || b != 0) ? 1 : 0;
            4:       r = (a == full && b == full) ? 1 : 0;
            5:       r = (a << W) | b;
            7:       r = (a >= RW) ? 0 : (b << a);
            default: r = exp_result;
        endcase
        return r & ((1 << RW) - 1);
    endfunction

    task automatic model_reset();
        exp_result = 0;
        exp_done   = 0;
        mul_left   = 0;
        mul_prod   = 0;
    endtask

    task automatic model_edge(input logic st, input int unsigned op, input int unsigned a,
                              input int unsigned b, input logic ua);
        int unsigned bop;
        exp_done = 0;
        if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) begin
                exp_result = mul_prod;
                exp_done   = 1;
            end
        end else if (st) begin
            bop = ua ? (exp_result & ((1 << W) - 1)) : b;
            if (op == 6) begin
                mul_prod = a * bop;
                mul_left = W;
            end else begin
                exp_result = model_op(op, a, bop);
                exp_done   = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".result"}, int'(bus.result), exp_result);
        check({tag, ".busy"}, int'(bus.busy), (mul_left > 0) ? 1 : 0);
        check({tag, ".done"}, int'(bus.done), exp_done);
    endtask

    task automatic step(input string tag, input logic st, input int unsigned op,
                        input int unsigned a, input int unsigned b, input logic ua);
        @(negedge clk);
        bus.start   = st;
        bus.op      = op[2:0];
        bus.a       = a[W-1:0];
        bus.b       = b[W-1:0];
        bus.use_acc = ua;
        @(posedge clk);
        model_edge(st, op, a, b, ua);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        resetn      = 1'b0;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.a       = '0;
        bus.b       = '0;
        bus.use_acc = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        step("add_ff", 1'b1, 1, 4'hF, 4'hF, 1'b0);
        check("add_ff.const", int'(bus.result), 32'h1E);
        idle("add_ff.after");
        step("cat_a5", 1'b1, 5, 4'hA, 4'h5, 1'b0);
        check("cat_a5.const", int'(bus.result), 32'hA5);

        step("chain_add", 1'b1, 1, 3, 4, 1'b0);
        step("chain_acc", 1'b1, 1, 2, 4'hF, 1'b1);
        check("chain_acc.const", int'(bus.result), 32'h09);
        step("chain_mul", 1'b1, 6, 3, 4'hF, 1'b1);
        for (int unsigned i = 0; i < W; i++) idle("chain_mul.wait");
        check("chain_mul.const", int'(bus.result), 32'h1B);

        step("mul_ff", 1'b1, 6, 4'hF, 4'hF, 1'b0);
        for (int unsigned i = 1; i < W; i++) step("mul_ff.ignored", 1'b1, 5, 4'h1, 4'h2, 1'b0);
        step("mul_ff.last", 1'b1, 1, 4'h1, 4'h1, 1'b0);
        check("mul_ff.const", int'(bus.result), 32'hE1);
        step("mul_back2back", 1'b1, 1, 4'h1, 4'h1, 1'b0);
        check("mul_back2back.const", int'(bus.result), 32'h02);

        step("mul_abort", 1'b1, 6, 4'hF, 4'hF, 1'b0);
        idle("mul_abort.1");
        idle("mul_abort.2");
        #2 resetn = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(negedge clk);
        resetn = 1'b1;
        step("logic_ca", 1'b1, 2, 4'hC, 4'hA, 1'b0);
        check("logic_ca.const", int'(bus.result), 32'hE6);

        step("shl_3_5", 1'b1, 7, 3, 5, 1'b0);
        check("shl_3_5.const", int'(bus.result), 32'h28);
        step("shl_8_5", 1'b1, 7, 8, 5, 1'b0);
        check("shl_8_5.const", int'(bus.result), 32'h00);
        step("ror_00", 1'b1, 3, 0, 0, 1'b0);
        check("ror_00.const", int'(bus.result), 32'h00);
        step("rand_ff", 1'b1, 4, 4'hF, 4'hF, 1'b0);
        check("rand_ff.const", int'(bus.result), 32'h01);
        step("hold", 1'b1, 0, 4'h3, 4'h3, 1'b0);
        check("hold.const", int'(bus.result), 32'h01);

        for (int unsigned i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 9) < 7), $urandom_range(0, 7),
                 $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
